// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the RV32 core: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and counts retirements.
module multicycle_ctrl #(
    parameter logic [2:0]  RESET_STATE = 3'd0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       imm_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             instr_done,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             opc_legal;
    logic             unused_instr;

    assign unused_instr = ^instr[31:7];

    // Legality is judged on the live IR since op_q only captures it at the end of DECODE.
    always_comb begin
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_JALR,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP: opc_legal = 1'b1;
            default:                             opc_legal = 1'b0;
        endcase
    end

    // State, latched opcode and retirement counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= state_t'(RESET_STATE);
            op_q  <= 7'd0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= instr[6:0];
            end
            if (instr_done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state and datapath control; everything is forced low while rst is high.
    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        imm_sel    = 3'd0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        reg_we     = 1'b0;
        wb_sel     = 2'b00;
        instr_done = 1'b0;
        trap       = 1'b0;

        case (op_q)
            OPC_STORE:          imm_sel = 3'd1;
            OPC_BRANCH:         imm_sel = 3'd2;
            OPC_LUI, OPC_AUIPC: imm_sel = 3'd3;
            OPC_JAL:            imm_sel = 3'd4;
            default:            imm_sel = 3'd0;
        endcase

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = opc_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_src = (op_q != OPC_OP) && (op_q != OPC_BRANCH);
                case (op_q)
                    OPC_BRANCH: begin
                        alu_op     = 2'b01;
                        pc_we      = 1'b1;
                        pc_sel     = branch_taken ? 2'b01 : 2'b00;
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        state_nxt = S_MEM;
                    end
                    OPC_OP, OPC_OPIMM: begin
                        alu_op    = 2'b10;
                        state_nxt = S_WB;
                    end
                    default: begin
                        state_nxt = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OPC_STORE);
                if (dmem_ready) begin
                    if (op_q == OPC_STORE) begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
                case (op_q)
                    OPC_LOAD:          wb_sel = 2'b01;
                    OPC_JAL, OPC_JALR: wb_sel = 2'b10;
                    OPC_LUI:           wb_sel = 2'b11;
                    default:           wb_sel = 2'b00;
                endcase
                case (op_q)
                    OPC_JAL:  pc_sel = 2'b01;
                    OPC_JALR: pc_sel = 2'b10;
                    default:  pc_sel = 2'b00;
                endcase
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        if (rst) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_sel     = 2'b00;
            imm_sel    = 3'd0;
            alu_src    = 1'b0;
            alu_op     = 2'b00;
            reg_we     = 1'b0;
            wb_sel     = 2'b00;
            instr_done = 1'b0;
            trap       = 1'b0;
        end
    end

    assign retired = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default build plus a CNT_W=4 build).
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0]  pc_sel, alu_op, wb_sel;
    logic [2:0]  imm_sel;
    logic        alu_src, reg_we, instr_done, trap;
    logic [31:0] retired;

    logic        imem_req4, dmem_req4, dmem_we4, ir_we4, pc_we4;
    logic [1:0]  pc_sel4, alu_op4, wb_sel4;
    logic [2:0]  imm_sel4;
    logic        alu_src4, reg_we4, instr_done4, trap4;
    logic [3:0]  retired4;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_src(alu_src),
        .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .instr_done(instr_done),
        .trap(trap), .retired(retired)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req4), .dmem_req(dmem_req4), .dmem_we(dmem_we4), .ir_we(ir_we4),
        .pc_we(pc_we4), .pc_sel(pc_sel4), .imm_sel(imm_sel4), .alu_src(alu_src4),
        .alu_op(alu_op4), .reg_we(reg_we4), .wb_sel(wb_sel4), .instr_done(instr_done4),
        .trap(trap4), .retired(retired4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH until it retires; dwait = dmem wait cycles.
    task automatic run_instr(input logic [31:0] ins, input logic bt, input int dwait,
                             output int lat, output int ndone,
                             output logic [1:0] d_pc_sel, output logic [1:0] d_wb_sel,
                             output logic d_reg_we, output logic [2:0] ex_imm,
                             output logic [1:0] ex_alu_op, output logic ex_alu_src,
                             output int nreq, output int nwe);
        lat = 0; ndone = 0; nreq = 0; nwe = 0;
        d_pc_sel = 2'b11; d_wb_sel = 2'b11; d_reg_we = 1'b0;
        ex_imm = 3'd7; ex_alu_op = 2'b11; ex_alu_src = 1'b0;
        instr = ins; branch_taken = bt; imem_ready = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (dmem_req) begin
                nreq++;
                dmem_ready = (nreq > dwait);
            end else begin
                dmem_ready = 1'b0;
            end
            #1;
            if (dmem_we) nwe++;
            if (cyc == 3) begin
                ex_imm = imm_sel; ex_alu_op = alu_op; ex_alu_src = alu_src;
            end
            if (instr_done) begin
                ndone++; lat = cyc;
                d_pc_sel = pc_sel; d_wb_sel = wb_sel; d_reg_we = reg_we;
            end
            tick();
            if (ndone != 0) break;
        end
        dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'h0050_0093; imem_ready = 1'b1;
        dmem_ready = 1'b0; branch_taken = 1'b0;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %0b want 0", imem_req); end
        checks++; if (ir_we !== 1'b0) begin errors++; $display("FAIL rst_ir_we: got %0b want 0", ir_we); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL rst_trap: got %0b want 0", trap); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rst_retired: got %0d want 0", retired); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_fetch_req: got %0b want 1", imem_req); end
        checks++; if (ir_we !== 1'b1) begin errors++; $display("FAIL rst_fetch_ir_we: got %0b want 1", ir_we); end
    endtask

    task automatic test_addi();
        tick();
        checks++; if ({imem_req, pc_we, reg_we} !== 3'b000) begin errors++; $display("FAIL addi_decode: got %b want 000", {imem_req, pc_we, reg_we}); end
        tick();
        checks++; if (alu_op !== 2'b10) begin errors++; $display("FAIL addi_alu_op: got %b want 10", alu_op); end
        checks++; if (alu_src !== 1'b1) begin errors++; $display("FAIL addi_alu_src: got %b want 1", alu_src); end
        checks++; if (imm_sel !== 3'd0) begin errors++; $display("FAIL addi_imm_sel: got %0d want 0", imm_sel); end
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL addi_exec_reg_we: got %b want 0", reg_we); end
        tick();
        checks++; if ({reg_we, pc_we, instr_done} !== 3'b111) begin errors++; $display("FAIL addi_wb: got %b want 111", {reg_we, pc_we, instr_done}); end
        checks++; if (wb_sel !== 2'b00) begin errors++; $display("FAIL addi_wb_sel: got %b want 00", wb_sel); end
        tick();
        checks++; if (retired !== 32'd1) begin errors++; $display("FAIL addi_retired: got %0d want 1", retired); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL addi_refetch: got %b want 1", imem_req); end
    endtask

    task automatic test_load_store();
        int lat, nd, nreq, nwe;
        logic [1:0] ps, ws, ao;
        logic rw, as;
        logic [2:0] im;
        run_instr(32'h0002_A303, 1'b0, 3, lat, nd, ps, ws, rw, im, ao, as, nreq, nwe);
        checks++; if (lat !== 8) begin errors++; $display("FAIL lw_latency: got %0d want 8", lat); end
        checks++; if (nreq !== 4) begin errors++; $display("FAIL lw_dmem_req_cycles: got %0d want 4", nreq); end
        checks++; if (nwe !== 0) begin errors++; $display("FAIL lw_dmem_we: got %0d want 0", nwe); end
        checks++; if (ws !== 2'b01) begin errors++; $display("FAIL lw_wb_sel: got %b want 01", ws); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL lw_single_pulse: got %b want 0", instr_done); end
        checks++; if (retired !== 32'd2) begin errors++; $display("FAIL lw_retired: got %0d want 2", retired); end
        run_instr(32'h0050_2023, 1'b0, 0, lat, nd, ps, ws, rw, im, ao, as, nreq, nwe);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sw_latency: got %0d want 4", lat); end
        checks++; if (nwe !== 1) begin errors++; $display("FAIL sw_dmem_we: got %0d want 1", nwe); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL sw_reg_we: got %b want 0", rw); end
        checks++; if (im !== 3'd1) begin errors++; $display("FAIL sw_imm_sel: got %0d want 1", im); end
    endtask

    task automatic test_branch();
        int lat, nd, nreq, nwe;
        logic [1:0] ps, ws, ao;
        logic rw, as;
        logic [2:0] im;
        run_instr(32'h0020_8463, 1'b1, 0, lat, nd, ps, ws, rw, im, ao, as, nreq, nwe);
        checks++; if (lat !== 3) begin errors++; $display("FAIL beq_t_latency: got %0d want 3", lat); end
        checks++; if (ps !== 2'b01) begin errors++; $display("FAIL beq_t_pc_sel: got %b want 01", ps); end
        checks++; if (im !== 3'd2) begin errors++; $display("FAIL beq_imm_sel: got %0d want 2", im); end
        checks++; if ({ao, as} !== 3'b010) begin errors++; $display("FAIL beq_alu: got %b want 010", {ao, as}); end
        run_instr(32'h0020_8463, 1'b0, 0, lat, nd, ps, ws, rw, im, ao, as, nreq, nwe);
        checks++; if (lat !== 3) begin errors++; $display("FAIL beq_nt_latency: got %0d want 3", lat); end
        checks++; if (ps !== 2'b00) begin errors++; $display("FAIL beq_nt_pc_sel: got %b want 00", ps); end
    endtask

    task automatic test_jumps();
        int lat, nd, nreq, nwe;
        logic [1:0] ps, ws, ao;
        logic rw, as;
        logic [2:0] im;
        run_instr(32'h0000_80E7, 1'b0, 0, lat, nd, ps, ws, rw, im, ao, as, nreq, nwe);
        checks++; if (im !== 3'd0) begin errors++; $display("FAIL jalr_imm_sel: got %0d want 0", im); end
        checks++; if (ws !== 2'b10) begin errors++; $display("FAIL jalr_wb_sel: got %b want 10", ws); end
        checks++; if (ps !== 2'b10) begin errors++; $display("FAIL jalr_pc_sel: got %b want 10", ps); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL jalr_latency: got %0d want 4", lat); end
        run_instr(32'h0080_00EF, 1'b0, 0, lat, nd, ps, ws, rw, im, ao, as, nreq, nwe);
        checks++; if (im !== 3'd4) begin errors++; $display("FAIL jal_imm_sel: got %0d want 4", im); end
        checks++; if (ps !== 2'b01) begin errors++; $display("FAIL jal_pc_sel: got %b want 01", ps); end
        checks++; if (ws !== 2'b10) begin errors++; $display("FAIL jal_wb_sel: got %b want 10", ws); end
        checks++; if (retired !== 32'd7) begin errors++; $display("FAIL jumps_retired: got %0d want 7", retired); end
    endtask

    task automatic test_trap();
        int viol = 0;
        int trap_lo = 0;
        instr = 32'hFFFF_FFFF; imem_ready = 1'b1; dmem_ready = 1'b1;
        tick();
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL trap_in_decode: got %b want 0", trap); end
        tick();
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL trap_rise: got %b want 1", trap); end
        for (int i = 0; i < 22; i++) begin
            if (pc_we || reg_we || imem_req || dmem_req || instr_done) viol++;
            if (trap !== 1'b1) trap_lo++;
            tick();
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL trap_enables: got %0d active cycles want 0", viol); end
        checks++; if (trap_lo !== 0) begin errors++; $display("FAIL trap_sticky: got %0d low cycles want 0", trap_lo); end
        dmem_ready = 1'b0;
        do_reset();
        checks++; if ({trap, imem_req} !== 2'b01) begin errors++; $display("FAIL trap_reset: got %b want 01", {trap, imem_req}); end
    endtask

    task automatic test_wrap();
        int lat, nd, nreq, nwe;
        logic [1:0] ps, ws, ao;
        logic rw, as;
        logic [2:0] im;
        for (int i = 0; i < 15; i++) begin
            run_instr(32'h0050_0093, 1'b0, 0, lat, nd, ps, ws, rw, im, ao, as, nreq, nwe);
        end
        checks++; if (retired4 !== 4'hF) begin errors++; $display("FAIL wrap_at_max: got %0d want 15", retired4); end
        run_instr(32'h0050_0093, 1'b0, 0, lat, nd, ps, ws, rw, im, ao, as, nreq, nwe);
        checks++; if (retired4 !== 4'h0) begin errors++; $display("FAIL wrap_to_zero: got %0d want 0", retired4); end
        checks++; if (retired !== 32'd16) begin errors++; $display("FAIL wrap_wide_cnt: got %0d want 16", retired); end
    endtask

    task automatic test_reset_in_mem();
        instr = 32'h0050_2023; imem_ready = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if ({dmem_req, dmem_we} !== 2'b11) begin errors++; $display("FAIL mem_wait_req: got %b want 11", {dmem_req, dmem_we}); end
        rst = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++; if ({dmem_req, dmem_we, pc_we, instr_done} !== 4'b0000) begin errors++; $display("FAIL mem_rst_drop: got %b want 0000", {dmem_req, dmem_we, pc_we, instr_done}); end
        checks++; if (imm_sel !== 3'd0) begin errors++; $display("FAIL mem_rst_imm_sel: got %0d want 0", imm_sel); end
        tick();
        rst = 1'b0; dmem_ready = 1'b0;
        #1;
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL mem_rst_retired: got %0d want 0", retired); end
        checks++; if ({imem_req, dmem_req} !== 2'b10) begin errors++; $display("FAIL mem_rst_refetch: got %b want 10", {imem_req, dmem_req}); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_store();
        test_branch();
        test_jumps();
        test_trap();
        test_wrap();
        test_reset_in_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
